// File: rtl/reorder_buffer_if.sv
// Dispatcher, CDB, operand-query and commit/rollback signals of the reorder buffer.
// The master side is the core (dispatcher/CDB/register file), the slave side is the buffer.
interface reorder_buffer_if #(parameter int ROB_ID_W = 4);
    logic                rdy;
    logic                alloc_signal_from_dispatcher;
    logic [4:0]          rd_from_dispatcher;
    logic                is_jump_from_dispatcher;
    logic [ROB_ID_W-1:0] rob_id_for_rd;
    logic                rob_full;
    logic                cdb_valid;
    logic [ROB_ID_W-1:0] cdb_rob_id;
    logic [31:0]         cdb_value;
    logic                cdb_mispredict;
    logic [31:0]         cdb_target_pc;
    logic [ROB_ID_W-1:0] query_id1;
    logic [ROB_ID_W-1:0] query_id2;
    logic                query_ready1;
    logic                query_ready2;
    logic [31:0]         query_value1;
    logic [31:0]         query_value2;
    logic                commit_flag;
    logic [4:0]          rd_to_reg;
    logic [ROB_ID_W-1:0] Q_to_reg;
    logic [31:0]         V_to_reg;
    logic                rollback_flag;
    logic [31:0]         rollback_pc;

    modport master (
        output rdy, alloc_signal_from_dispatcher, rd_from_dispatcher, is_jump_from_dispatcher,
        output cdb_valid, cdb_rob_id, cdb_value, cdb_mispredict, cdb_target_pc,
        output query_id1, query_id2,
        input  rob_id_for_rd, rob_full, query_ready1, query_ready2, query_value1, query_value2,
        input  commit_flag, rd_to_reg, Q_to_reg, V_to_reg, rollback_flag, rollback_pc
    );

    modport slave (
        input  rdy, alloc_signal_from_dispatcher, rd_from_dispatcher, is_jump_from_dispatcher,
        input  cdb_valid, cdb_rob_id, cdb_value, cdb_mispredict, cdb_target_pc,
        input  query_id1, query_id2,
        output rob_id_for_rd, rob_full, query_ready1, query_ready2, query_value1, query_value2,
        output commit_flag, rd_to_reg, Q_to_reg, V_to_reg, rollback_flag, rollback_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocate at tail, complete via CDB, commit/rollback at head.
// Optional macro ROB_BYPASS_EN forwards a same-cycle CDB broadcast to the operand queries.
module reorder_buffer #(
    parameter int ROB_ID_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    reorder_buffer_if.slave rob
);
    localparam int DEPTH = 1 << ROB_ID_W;
    localparam logic [ROB_ID_W-1:0] ZERO_ROB = '0;
    localparam logic [ROB_ID_W-1:0] FIRST_ID = ROB_ID_W'(1);
    localparam logic [ROB_ID_W-1:0] LAST_ID  = ROB_ID_W'(DEPTH - 1);
    localparam logic [ROB_ID_W-1:0] FULL_AT  = ROB_ID_W'(DEPTH - 2);

    // Slot 0 exists only so ids index directly; it is never allocated.
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_ready;
    logic [DEPTH-1:0] ent_jump;
    logic [DEPTH-1:0] ent_mis;
    logic [4:0]       ent_rd    [DEPTH];
    logic [31:0]      ent_value [DEPTH];
    logic [31:0]      ent_pc    [DEPTH];

    logic [ROB_ID_W-1:0] head;
    logic [ROB_ID_W-1:0] tail;
    logic [ROB_ID_W-1:0] count;

    logic commit_now;
    logic rollback_now;
    logic alloc_now;
    logic wb_now;

    function automatic logic [ROB_ID_W-1:0] next_id(input logic [ROB_ID_W-1:0] id);
        return (id == LAST_ID) ? FIRST_ID : id + FIRST_ID;
    endfunction

    assign commit_now   = rob.rdy && ent_valid[head] && ent_ready[head];
    assign rollback_now = commit_now && ent_jump[head] && ent_mis[head];
    // The count guard only protects against a dispatcher ignoring rob_full.
    assign alloc_now    = rob.rdy && rob.alloc_signal_from_dispatcher && !rollback_now
                          && (count != LAST_ID);
    assign wb_now       = rob.rdy && rob.cdb_valid && (rob.cdb_rob_id != ZERO_ROB)
                          && ent_valid[rob.cdb_rob_id];

    assign rob.rob_id_for_rd = tail;
    assign rob.rob_full      = (count >= FULL_AT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid <= '0;
            ent_ready <= '0;
            ent_jump  <= '0;
            ent_mis   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd[i]    <= '0;
                ent_value[i] <= '0;
                ent_pc[i]    <= '0;
            end
            head  <= FIRST_ID;
            tail  <= FIRST_ID;
            count <= '0;
        end else begin
            if (wb_now) begin
                ent_ready[rob.cdb_rob_id] <= 1'b1;
                ent_value[rob.cdb_rob_id] <= rob.cdb_value;
                ent_mis[rob.cdb_rob_id]   <= rob.cdb_mispredict;
                ent_pc[rob.cdb_rob_id]    <= rob.cdb_target_pc;
            end
            if (rollback_now) begin
                ent_valid <= '0;
                head      <= FIRST_ID;
                tail      <= FIRST_ID;
                count     <= '0;
            end else begin
                if (commit_now) begin
                    ent_valid[head] <= 1'b0;
                    head            <= next_id(head);
                end
                if (alloc_now) begin
                    ent_valid[tail] <= 1'b1;
                    ent_ready[tail] <= 1'b0;
                    ent_mis[tail]   <= 1'b0;
                    ent_jump[tail]  <= rob.is_jump_from_dispatcher;
                    ent_rd[tail]    <= rob.rd_from_dispatcher;
                    tail            <= next_id(tail);
                end
                if (alloc_now && !commit_now) begin
                    count <= count + FIRST_ID;
                end else if (commit_now && !alloc_now) begin
                    count <= count - FIRST_ID;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rob.commit_flag   <= 1'b0;
            rob.rollback_flag <= 1'b0;
            rob.rd_to_reg     <= '0;
            rob.Q_to_reg      <= '0;
            rob.V_to_reg      <= '0;
            rob.rollback_pc   <= '0;
        end else begin
            rob.commit_flag   <= commit_now;
            rob.rollback_flag <= rollback_now;
            if (commit_now) begin
                rob.rd_to_reg <= ent_rd[head];
                rob.Q_to_reg  <= head;
                rob.V_to_reg  <= ent_value[head];
            end
            if (rollback_now) begin
                rob.rollback_pc <= ent_pc[head];
            end
        end
    end

    always_comb begin
        rob.query_ready1 = 1'b0;
        rob.query_value1 = '0;
        rob.query_ready2 = 1'b0;
        rob.query_value2 = '0;
        if (rob.query_id1 != ZERO_ROB) begin
            rob.query_ready1 = ent_valid[rob.query_id1] && ent_ready[rob.query_id1];
            rob.query_value1 = ent_value[rob.query_id1];
        end
        if (rob.query_id2 != ZERO_ROB) begin
            rob.query_ready2 = ent_valid[rob.query_id2] && ent_ready[rob.query_id2];
            rob.query_value2 = ent_value[rob.query_id2];
        end
`ifdef ROB_BYPASS_EN
        if (rob.cdb_valid && (rob.query_id1 != ZERO_ROB) && (rob.cdb_rob_id == rob.query_id1)) begin
            rob.query_ready1 = 1'b1;
            rob.query_value1 = rob.cdb_value;
        end
        if (rob.cdb_valid && (rob.query_id2 != ZERO_ROB) && (rob.cdb_rob_id == rob.query_id2)) begin
            rob.query_ready2 = 1'b1;
            rob.query_value2 = rob.cdb_value;
        end
`endif
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a vector table for the basic flows plus
// hand sequences for fill/wrap, rdy stall, query forwarding and mid-run reset.
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    reorder_buffer_if #(.ROB_ID_W(4)) rob_bus ();
    reorder_buffer #(.ROB_ID_W(4)) dut (.clk(clk), .rst(rst), .rob(rob_bus));

    typedef struct {
        int alloc, rd, jump, cv, cid, cval, mis, tpc, qid;
        int e_tail, e_full, e_qr, e_qv;
        int e_cf, e_rd, e_q, e_v, e_rb, e_pc;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        rob_bus.rdy                          = 1'b1;
        rob_bus.alloc_signal_from_dispatcher = 1'b0;
        rob_bus.rd_from_dispatcher           = '0;
        rob_bus.is_jump_from_dispatcher      = 1'b0;
        rob_bus.cdb_valid                    = 1'b0;
        rob_bus.cdb_rob_id                   = '0;
        rob_bus.cdb_value                    = '0;
        rob_bus.cdb_mispredict               = 1'b0;
        rob_bus.cdb_target_pc                = '0;
        rob_bus.query_id1                    = '0;
        rob_bus.query_id2                    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic alloc_one(input int rd);
        drive_idle();
        rob_bus.alloc_signal_from_dispatcher = 1'b1;
        rob_bus.rd_from_dispatcher           = 5'(rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_q;
        //           alloc rd jmp cv cid cval   mis tpc    qid | tail full qr qv     | cf rd q v       rb pc
        vecs[0]  = '{1, 5, 0,  0, 0, 0,       0, 0,     0,  1, 0, 0, 0,       0, 0, 0, 0,       0, 0};
        vecs[1]  = '{0, 0, 0,  1, 1, 'h1234,  0, 0,     0,  2, 0, 0, 0,       0, 0, 0, 0,       0, 0};
        vecs[2]  = '{0, 0, 0,  0, 0, 0,       0, 0,     1,  2, 0, 1, 'h1234,  1, 5, 1, 'h1234,  0, 0};
        vecs[3]  = '{0, 0, 0,  0, 0, 0,       0, 0,     0,  2, 0, 0, 0,       0, 5, 1, 'h1234,  0, 0};
        vecs[4]  = '{1, 1, 0,  0, 0, 0,       0, 0,     0,  2, 0, 0, 0,       0, 5, 1, 'h1234,  0, 0};
        vecs[5]  = '{1, 2, 0,  0, 0, 0,       0, 0,     0,  3, 0, 0, 0,       0, 5, 1, 'h1234,  0, 0};
        vecs[6]  = '{1, 3, 0,  0, 0, 0,       0, 0,     0,  4, 0, 0, 0,       0, 5, 1, 'h1234,  0, 0};
        vecs[7]  = '{0, 0, 0,  1, 4, 'h44,    0, 0,     0,  5, 0, 0, 0,       0, 5, 1, 'h1234,  0, 0};
        vecs[8]  = '{0, 0, 0,  1, 2, 'h22,    0, 0,     0,  5, 0, 0, 0,       0, 5, 1, 'h1234,  0, 0};
        vecs[9]  = '{0, 0, 0,  1, 3, 'h33,    0, 0,     2,  5, 0, 1, 'h22,    1, 1, 2, 'h22,    0, 0};
        vecs[10] = '{0, 0, 0,  0, 0, 0,       0, 0,     4,  5, 0, 1, 'h44,    1, 2, 3, 'h33,    0, 0};
        vecs[11] = '{0, 0, 0,  0, 0, 0,       0, 0,     0,  5, 0, 0, 0,       1, 3, 4, 'h44,    0, 0};
        vecs[12] = '{0, 0, 0,  0, 0, 0,       0, 0,     0,  5, 0, 0, 0,       0, 3, 4, 'h44,    0, 0};
        vecs[13] = '{1, 0, 1,  0, 0, 0,       0, 0,     0,  5, 0, 0, 0,       0, 3, 4, 'h44,    0, 0};
        vecs[14] = '{1, 7, 0,  0, 0, 0,       0, 0,     0,  6, 0, 0, 0,       0, 3, 4, 'h44,    0, 0};
        vecs[15] = '{0, 0, 0,  1, 5, 'h55,    1, 'h100, 0,  7, 0, 0, 0,       0, 3, 4, 'h44,    0, 0};
        vecs[16] = '{1, 9, 0,  0, 0, 0,       0, 0,     0,  7, 0, 0, 0,       1, 0, 5, 'h55,    1, 'h100};
        vecs[17] = '{0, 0, 0,  0, 0, 0,       0, 0,     6,  1, 0, 0, 0,       0, 0, 5, 'h55,    0, 'h100};
        vecs[18] = '{1, 4, 0,  0, 0, 0,       0, 0,     0,  1, 0, 0, 0,       0, 0, 5, 'h55,    0, 'h100};
        vecs[19] = '{0, 0, 0,  0, 0, 0,       0, 0,     0,  2, 0, 0, 0,       0, 0, 5, 'h55,    0, 'h100};
        vecs[20] = '{0, 0, 0,  1, 1, 'h77,    0, 0,     0,  2, 0, 0, 0,       0, 0, 5, 'h55,    0, 'h100};
        vecs[21] = '{0, 0, 0,  0, 0, 0,       0, 0,     0,  2, 0, 0, 0,       1, 4, 1, 'h77,    0, 'h100};
        vecs[22] = '{0, 0, 0,  0, 0, 0,       0, 0,     0,  2, 0, 0, 0,       0, 4, 1, 'h77,    0, 'h100};

        do_reset();
        chk("reset rob_id_for_rd", 32'(rob_bus.rob_id_for_rd), 1);
        chk("reset rob_full", 32'(rob_bus.rob_full), 0);
        chk("reset commit_flag", 32'(rob_bus.commit_flag), 0);
        chk("reset rollback_flag", 32'(rob_bus.rollback_flag), 0);
        chk("reset V_to_reg", rob_bus.V_to_reg, 0);
        chk("reset Q_to_reg", 32'(rob_bus.Q_to_reg), 0);

        for (int i = 0; i < 23; i++) begin
            drive_idle();
            rob_bus.alloc_signal_from_dispatcher = 1'(vecs[i].alloc);
            rob_bus.rd_from_dispatcher           = 5'(vecs[i].rd);
            rob_bus.is_jump_from_dispatcher      = 1'(vecs[i].jump);
            rob_bus.cdb_valid                    = 1'(vecs[i].cv);
            rob_bus.cdb_rob_id                   = 4'(vecs[i].cid);
            rob_bus.cdb_value                    = 32'(vecs[i].cval);
            rob_bus.cdb_mispredict               = 1'(vecs[i].mis);
            rob_bus.cdb_target_pc                = 32'(vecs[i].tpc);
            rob_bus.query_id1                    = 4'(vecs[i].qid);
            #1;
            chk($sformatf("v%0d rob_id_for_rd", i), 32'(rob_bus.rob_id_for_rd), 32'(vecs[i].e_tail));
            chk($sformatf("v%0d rob_full", i), 32'(rob_bus.rob_full), 32'(vecs[i].e_full));
            chk($sformatf("v%0d query_ready1", i), 32'(rob_bus.query_ready1), 32'(vecs[i].e_qr));
            chk($sformatf("v%0d query_value1", i), rob_bus.query_value1, 32'(vecs[i].e_qv));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d commit_flag", i), 32'(rob_bus.commit_flag), 32'(vecs[i].e_cf));
            chk($sformatf("v%0d rd_to_reg", i), 32'(rob_bus.rd_to_reg), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d Q_to_reg", i), 32'(rob_bus.Q_to_reg), 32'(vecs[i].e_q));
            chk($sformatf("v%0d V_to_reg", i), rob_bus.V_to_reg, 32'(vecs[i].e_v));
            chk($sformatf("v%0d rollback_flag", i), 32'(rob_bus.rollback_flag), 32'(vecs[i].e_rb));
            chk($sformatf("v%0d rollback_pc", i), rob_bus.rollback_pc, 32'(vecs[i].e_pc));
        end

        // Fill to the full threshold, drain in order, then check the id wrap skips 0.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive_idle();
            #1;
            chk($sformatf("fill%0d rob_id_for_rd", i), 32'(rob_bus.rob_id_for_rd), 32'(i + 1));
            chk($sformatf("fill%0d rob_full", i), 32'(rob_bus.rob_full), 0);
            alloc_one(i + 1);
        end
        drive_idle();
        #1;
        chk("full rob_full", 32'(rob_bus.rob_full), 1);
        chk("full rob_id_for_rd", 32'(rob_bus.rob_id_for_rd), 15);
        exp_q = 1;
        for (int c = 0; c < 24; c++) begin
            drive_idle();
            if (c < 14) begin
                rob_bus.cdb_valid  = 1'b1;
                rob_bus.cdb_rob_id = 4'(c + 1);
                rob_bus.cdb_value  = 32'((c + 1) * 16);
            end
            @(posedge clk);
            #1;
            if (rob_bus.commit_flag) begin
                chk("drain Q_to_reg", 32'(rob_bus.Q_to_reg), 32'(exp_q));
                chk("drain V_to_reg", rob_bus.V_to_reg, 32'(exp_q * 16));
                chk("drain rd_to_reg", 32'(rob_bus.rd_to_reg), 32'(exp_q));
                exp_q++;
            end
        end
        chk("drain commit count", 32'(exp_q - 1), 14);
        drive_idle();
        #1;
        chk("drained rob_full", 32'(rob_bus.rob_full), 0);
        chk("wrap id before", 32'(rob_bus.rob_id_for_rd), 15);
        alloc_one(3);
        chk("wrap id after 15", 32'(rob_bus.rob_id_for_rd), 1);
        alloc_one(3);
        chk("wrap id after 1", 32'(rob_bus.rob_id_for_rd), 2);

        // rdy low stalls a ready head and any allocation.
        do_reset();
        alloc_one(6);
        drive_idle();
        rob_bus.cdb_valid  = 1'b1;
        rob_bus.cdb_rob_id = 4'd1;
        rob_bus.cdb_value  = 32'h99;
        @(posedge clk);
        #1;
        drive_idle();
        rob_bus.rdy = 1'b0;
        rob_bus.alloc_signal_from_dispatcher = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d commit_flag", i), 32'(rob_bus.commit_flag), 0);
            chk($sformatf("stall%0d rob_id_for_rd", i), 32'(rob_bus.rob_id_for_rd), 2);
        end
        drive_idle();
        @(posedge clk);
        #1;
        chk("resume commit_flag", 32'(rob_bus.commit_flag), 1);
        chk("resume Q_to_reg", 32'(rob_bus.Q_to_reg), 1);
        chk("resume V_to_reg", rob_bus.V_to_reg, 32'h99);
        chk("resume rd_to_reg", 32'(rob_bus.rd_to_reg), 6);
        @(posedge clk);
        #1;
        chk("resume pulse width", 32'(rob_bus.commit_flag), 0);

        // Query forwarding, id 0 / invalid-entry broadcasts, then reset mid-pulse.
        do_reset();
        for (int i = 0; i < 4; i++) alloc_one(i + 10);
        drive_idle();
        rob_bus.cdb_valid  = 1'b1;
        rob_bus.cdb_rob_id = 4'd4;
        rob_bus.cdb_value  = 32'hAB;
        rob_bus.query_id1  = 4'd4;
        #1;
`ifdef ROB_BYPASS_EN
        chk("bypass query_ready1", 32'(rob_bus.query_ready1), 1);
        chk("bypass query_value1", rob_bus.query_value1, 32'hAB);
`else
        chk("bypass query_ready1", 32'(rob_bus.query_ready1), 0);
        chk("bypass query_value1", rob_bus.query_value1, 0);
`endif
        chk("bypass query_ready2 id0", 32'(rob_bus.query_ready2), 0);
        @(posedge clk);
        #1;
        drive_idle();
        rob_bus.query_id2 = 4'd4;
        #1;
        chk("stored query_ready2", 32'(rob_bus.query_ready2), 1);
        chk("stored query_value2", rob_bus.query_value2, 32'hAB);
        drive_idle();
        rob_bus.cdb_valid  = 1'b1;
        rob_bus.cdb_rob_id = 4'd10;
        rob_bus.cdb_value  = 32'h5A;
        @(posedge clk);
        #1;
        rob_bus.cdb_rob_id = 4'd0;
        rob_bus.query_id1  = 4'd10;
        rob_bus.query_id2  = 4'd0;
        #1;
        chk("invalid-entry wb ignored", 32'(rob_bus.query_ready1), 0);
        chk("id0 query_ready2", 32'(rob_bus.query_ready2), 0);
        chk("id0 query_value2", rob_bus.query_value2, 0);
        @(posedge clk);
        #1;
        chk("id0 cdb no commit", 32'(rob_bus.commit_flag), 0);
        drive_idle();
        rob_bus.cdb_valid  = 1'b1;
        rob_bus.cdb_rob_id = 4'd1;
        rob_bus.cdb_value  = 32'h11;
        @(posedge clk);
        #1;
        drive_idle();
        chk("same-edge wb no commit", 32'(rob_bus.commit_flag), 0);
        @(posedge clk);
        #1;
        chk("late commit_flag", 32'(rob_bus.commit_flag), 1);
        chk("late Q_to_reg", 32'(rob_bus.Q_to_reg), 1);
        rst = 1'b1;
        #1;
        chk("async rst commit_flag", 32'(rob_bus.commit_flag), 0);
        chk("async rst rob_id_for_rd", 32'(rob_bus.rob_id_for_rd), 1);
        chk("async rst V_to_reg", rob_bus.V_to_reg, 0);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
